// File: rtl/code_link_pkg.sv
// Shared constants and types for the 16-bit RLE code link (transmitter and receiver).
package code_link_pkg;

    localparam int CODE_CLKS_PER_BIT = 435;
    localparam int CODE_DATA_BITS    = 16;
    // start + data + stop
    localparam int CODE_FRAME_BITS   = CODE_DATA_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/code_fifo.sv
// Synchronous show-ahead FIFO: rdata is always the head word, level is the occupancy.
// DEPTH must be a power of two so the pointers wrap for free.
module code_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/code_rx_fifo.sv
// Serial receiver for the RLE code link: 2-flop synchronizer, framing FSM and a
// show-ahead word FIFO drained by the run-length decoder via valid/ready.
module code_rx_fifo
    import code_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CODE_CLKS_PER_BIT,
    parameter int DATA_BITS    = CODE_DATA_BITS,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          valid,
    input  logic                          ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_BIT    = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 din_s;
    logic                 din_prev;
    rx_state_e            state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_req;
    logic                 bad_stop;
    logic                 pop;
    logic                 full;
    logic                 empty;

    assign valid = !empty;
    assign pop   = valid && ready;

    // Synchronize the line and keep one more delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            din_s    <= 1'b1;
            din_prev <= 1'b1;
        end else begin
            sync1    <= din;
            din_s    <= sync1;
            din_prev <= din_s;
        end
    end

    // Framing FSM: mid-bit sampling off the start edge, one-cycle push/error strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
            bad_stop <= 1'b0;
        end else begin
            push_req <= 1'b0;
            bad_stop <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_prev && !din_s) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (timer == T_HALF) begin
                        timer <= '0;
                        state <= din_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == T_BIT) begin
                        timer   <= '0;
                        // Shifting in from the top leaves bit k at index k after DATA_BITS samples.
                        shreg   <= {din_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == T_BIT) begin
                        timer <= '0;
                        if (din_s) begin
                            push_req <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bad_stop <= 1'b1;
                            state    <= WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // A held-low line (break) must go high before a new start edge counts.
                WAIT_IDLE: begin
                    if (din_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status pulses line up with the cycle the pushed word becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overflow  <= push_req && full && !pop;
        end
    end

    code_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (shreg),
        .rdata (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_code_rx_fifo.sv
// Bench for code_rx_fifo: table of single frames, hand-written corner sequences and a
// randomized run checked against a word-queue model of the link.
module tb_code_rx_fifo;
    import code_link_pkg::*;

    localparam int CPB   = 16;
    localparam int DB    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FB    = CODE_FRAME_BITS;
    // Stop-bit sample edge and output edge, as offsets from t0.
    localparam int STOP_T = 2 + CPB / 2 + (DB + 1) * CPB;
    localparam int OUT_T  = STOP_T + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b1;
    logic          ready = 1'b0;
    logic [DB-1:0] dout;
    logic          valid;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] level;

    code_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    int            n_err = 0, n_ovf = 0, n_vhi = 0, n_inv = 0;
    int            err_cyc = -1, ovf_cyc = -1, vrise_cyc = -1;
    logic          v_prev = 1'b0;
    logic [DB-1:0] rxq[$];

    always @(negedge clk) begin
        v_prev <= valid;
        if (!rst) begin
            if (frame_err) begin n_err <= n_err + 1; err_cyc <= cyc; end
            if (overflow)  begin n_ovf <= n_ovf + 1; ovf_cyc <= cyc; end
            if (valid) n_vhi <= n_vhi + 1;
            if (valid && !v_prev) vrise_cyc <= cyc;
            if (valid && ready) rxq.push_back(dout);
            if (valid != (level != '0)) n_inv <= n_inv + 1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive the first nbits of a frame; a bad stop is held low for 'hold' extra cycles.
    task automatic send_frame(input logic [DB-1:0] w, input bit stop_ok, input int hold,
                              input int nbits, output int t0);
        logic [FB-1:0] f;
        f  = {stop_ok, w, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            din = f[i];
            tick(CPB);
        end
        if (nbits == FB && !stop_ok) begin
            tick(hold);
            din = 1'b1;
            tick(CPB);
        end
    endtask

    typedef struct {
        logic [DB-1:0] word;
        bit            stop_ok;
        int            hold;
        bit            exp_push;
        bit            exp_err;
    } vec_t;

    vec_t          vt[6];
    int            t0, t0c, b_rx, b_err, b_ovf, b_vhi, exp_err, got;
    logic [DB-1:0] expq[$];
    logic [DB-1:0] w;
    bit            ok, done;

    initial begin
        vt[0] = '{16'hA5C3, 1'b1,    0, 1'b1, 1'b0};
        vt[1] = '{16'h1234, 1'b0, 1000, 1'b0, 1'b1};
        vt[2] = '{16'h0001, 1'b1,    0, 1'b1, 1'b0};
        vt[3] = '{16'hFFFF, 1'b1,    0, 1'b1, 1'b0};
        vt[4] = '{16'h0000, 1'b1,    0, 1'b1, 1'b0};
        vt[5] = '{16'h8001, 1'b0,    5, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("reset valid", valid, 0);
        chk("reset level", level, 0);
        chk("reset dout", dout, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overflow", overflow, 0);
        rst = 1'b0;
        tick(2 * CPB);

        // Single frames, consumer always ready
        ready = 1'b1;
        for (int i = 0; i < $size(vt); i++) begin
            b_rx = rxq.size(); b_err = n_err; b_vhi = n_vhi;
            send_frame(vt[i].word, vt[i].stop_ok, vt[i].hold, FB, t0);
            tick(2 * CPB);
            chk("vec pushes", rxq.size() - b_rx, vt[i].exp_push);
            if (vt[i].exp_push && rxq.size() > b_rx) begin
                chk("vec dout", rxq[b_rx], vt[i].word);
                chk("vec valid rise", vrise_cyc - t0, OUT_T);
                chk("vec valid width", n_vhi - b_vhi, 1);
            end
            chk("vec frame_err", n_err - b_err, vt[i].exp_err);
            if (vt[i].exp_err) chk("vec err time", err_cyc - t0, OUT_T);
            chk("vec level", level, 0);
        end

        // Overflow: five frames into a depth-4 FIFO with no consumer
        ready = 1'b0;
        b_rx = rxq.size(); b_ovf = n_ovf;
        for (int k = 1; k <= 5; k++) send_frame(DB'(k), 1'b1, 0, FB, t0);
        tick(2 * CPB);
        chk("ovf level", level, DEPTH);
        chk("ovf count", n_ovf - b_ovf, 1);
        chk("ovf time", ovf_cyc - t0, OUT_T);
        ready = 1'b1;
        tick(10);
        ready = 1'b0;
        chk("drain count", rxq.size() - b_rx, 4);
        for (int j = 0; j < 4 && b_rx + j < rxq.size(); j++) chk("drain order", rxq[b_rx + j], j + 1);
        chk("drain level", level, 0);

        // Push and pop on the same edge while full: no overflow, nothing lost
        b_rx = rxq.size(); b_ovf = n_ovf;
        for (int k = 0; k < 4; k++) send_frame(DB'(16'h11 + k), 1'b1, 0, FB, t0);
        tick(2 * CPB);
        chk("full level", level, DEPTH);
        t0c = cyc + 1;
        fork
            send_frame(16'h0015, 1'b1, 0, FB, t0);
            begin
                while (cyc < t0c + STOP_T) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        join
        tick(2 * CPB);
        chk("coincide level", level, DEPTH);
        chk("coincide overflow", n_ovf - b_ovf, 0);
        ready = 1'b1;
        tick(10);
        chk("coincide count", rxq.size() - b_rx, 5);
        for (int j = 0; j < 5 && b_rx + j < rxq.size(); j++) chk("coincide order", rxq[b_rx + j], 16'h11 + j);

        // Short low glitch while idle, then a real frame must still land on time
        b_rx = rxq.size(); b_err = n_err;
        din = 1'b0;
        tick(CPB / 2 - 3);
        din = 1'b1;
        tick(CPB / 2 + 6);
        chk("glitch push", rxq.size() - b_rx, 0);
        chk("glitch err", n_err - b_err, 0);
        send_frame(16'h5A3C, 1'b1, 0, FB, t0);
        tick(2 * CPB);
        chk("post-glitch count", rxq.size() - b_rx, 1);
        if (rxq.size() > b_rx) chk("post-glitch word", rxq[b_rx], 16'h5A3C);
        chk("post-glitch timing", vrise_cyc - t0, OUT_T);

        // Reset mid-frame with two words buffered
        ready = 1'b0;
        send_frame(16'h0021, 1'b1, 0, FB, t0);
        send_frame(16'h0022, 1'b1, 0, FB, t0);
        tick(4);
        chk("pre-reset level", level, 2);
        send_frame(16'hC0DE, 1'b1, 0, 9, t0);
        tick(CPB / 2);
        rst = 1'b1;
        din = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst valid", valid, 0);
        chk("rst level", level, 0);
        tick(3 * CPB);
        ready = 1'b1;
        b_rx = rxq.size(); b_err = n_err;
        send_frame(16'hBEEF, 1'b1, 0, FB, t0);
        tick(2 * CPB);
        chk("post-rst count", rxq.size() - b_rx, 1);
        if (rxq.size() > b_rx) chk("post-rst word", rxq[b_rx], 16'hBEEF);
        chk("post-rst err", n_err - b_err, 0);

        // Randomized back-to-back frames with a random consumer
        b_rx = rxq.size(); b_err = n_err; b_ovf = n_ovf;
        exp_err = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    w  = DB'($urandom);
                    ok = ($urandom_range(0, 4) != 0);
                    if (ok) expq.push_back(w);
                    else exp_err++;
                    send_frame(w, ok, $urandom_range(0, 40), FB, t0);
                end
                tick(2 * CPB);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        ready = 1'b1;
        tick(10);
        got = rxq.size() - b_rx;
        chk("rand count", got, expq.size());
        for (int j = 0; j < expq.size() && j < got; j++) chk("rand word", rxq[b_rx + j], expq[j]);
        chk("rand frame_err", n_err - b_err, exp_err);
        chk("rand overflow", n_ovf - b_ovf, 0);
        chk("rand level", level, 0);

        chk("valid tracks level", n_inv, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/code_rx_fifo.md
# code_rx_fifo

Serial receiver for the 16-bit RLE code link. It deserializes UART frames produced by the per-channel code transmitters. Each complete, well-framed word is pushed into a small show-ahead FIFO, which is drained by the run-length decoder through a valid/ready handshake. One instance sits on each colour channel, between the serial line and the decoder. Framing errors and overflows are flagged instead of being silently absorbed.

## Interface
Parameters:
- CLKS_PER_BIT, 435: clock cycles per serial bit.
- DATA_BITS, 16: payload bits per frame.
- FIFO_DEPTH, 4: words buffered; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- din  input  1  serial line; idles high; asynchronous to frame timing.
- dout  output  DATA_BITS  FIFO head word; valid only while valid=1.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts dout this cycle.
- frame_err  output  1  one-cycle pulse when a stop bit samples low.
- overflow  output  1  one-cycle pulse when a good word is dropped because the FIFO is full.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Frame format: 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high).
- din passes through a 2-flop synchronizer. All sampling uses the synchronized signal (din_s).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: a falling edge on din_s (previous 1, current 0) clears the bit counter and enters START.
- START: after CLKS_PER_BIT/2 cycles (integer division), sample din_s.
  - 0: clear the timer and go to DATA.
  - 1: glitch; return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, sample one bit into shift register bit index k (LSB first). After DATA_BITS samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample din_s.
  - 1: push the word to the FIFO and go to IDLE. If the FIFO is full and no pop occurs that cycle, drop the word and pulse overflow.
  - 0: pulse frame_err, discard the word, and go to WAIT_IDLE.
- WAIT_IDLE: stay until din_s=1, then go to IDLE. This prevents a break condition from being treated as a new start bit.
- FIFO behaviour:
  - Show-ahead: dout is the head word; valid = (level != 0).
  - A pop occurs when valid && ready.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overflow.
  - Push while empty: the word appears on dout with valid high on the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values, applied on a clk edge with rst=1:
  - FSM in IDLE; timer and bit counter cleared.
  - Synchronizer flops set to 1.
  - FIFO empty, so valid=0 and level=0.
  - dout=0, frame_err=0, overflow=0.
- rst mid-frame aborts the frame and flushes the FIFO. The next falling edge after rst deasserts starts a fresh frame.

## Timing
- t0 is the clk edge at which the first synchronizer flop captures din=0.
- The start edge is detected at t0+2.
- The start-bit sample is at t0+2+CLKS_PER_BIT/2; for defaults, t0+219.
- Data bit k is sampled at t0+219+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at t0+219+17·435 = t0+7614.
- valid rises at t0+7615 if the FIFO was empty.
- frame_err and overflow pulse on the cycle after the stop-bit sample (t0+7615) and last exactly 1 cycle.
- Back-to-back frames: a new start edge is accepted from the cycle the FSM returns to IDLE, so a stop bit followed immediately by the next start bit is received without loss.
- Pop takes effect on the edge where valid&&ready. The new head word and level are visible the next cycle.

## Structure
- Shared package (code_link_pkg):
  - CLKS_PER_BIT default and DATA_BITS, shared with the code transmitter.
  - Frame length constant (DATA_BITS+2).
  - FSM state enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
- Sub-module code_fifo: synchronous show-ahead FIFO with push, pop, full, empty and level. It is instantiated once.
- Synchronizer and FSM live in the top module.

## Test plan
- Drive the frame 0xA5C3 at 435 clks/bit, ready=1 → dout=0xA5C3 with valid high from t0+7615 for exactly 1 cycle; level returns to 0.
- Drive 0x1234 with the stop bit forced low, held low 1000 cycles, then released → frame_err pulse at t0+7615; no push; no spurious frame while the line is low; the next frame 0x0001 is received correctly.
- ready=0, send 5 frames 0x0001..0x0005 (FIFO_DEPTH=4) → level=4 and overflow pulses once on the 5th frame. Then ready=1 → pops return 0x0001..0x0004 in order and level reaches 0.
- 100-cycle low glitch on din while IDLE → no frame_err, no push, FSM back in IDLE by t0+220.
- Assert rst for 1 cycle at bit 8 of a frame while 2 words are buffered → valid=0, level=0 next cycle; the following full frame 0xBEEF is received correctly.
- Loop back from the code transmitter with continuous frames 0xFFFF, 0x8001, 0x0000, ready toggling every cycle → all three received in order, no errors, and pops coinciding with pushes while full produce no overflow.
